// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with registered one-hot grants, per-beat ack handshake
// and a limit of BURST acknowledged beats per grant before priority rotates.
module rr_burst_arbiter #(
   parameter int N     = 4,
   parameter int BURST = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N-1:0]         i_req,
   input  logic                 i_ack,
   output logic [N-1:0]         o_gnt,
   output logic [$clog2(N)-1:0] o_gnt_idx,
   output logic                 o_valid,
   output logic                 o_last
);

   localparam int IW = $clog2(N);
   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_idx;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_gnt;
   logic            r_valid;
   logic            r_last;

   logic [IW-1:0]   w_base;
   logic [IW-1:0]   w_sel;
   logic [N-1:0]    w_sel_oh;
   logic            w_found;
   logic            w_release;
   logic [CW-1:0]   w_cnt_nxt;

   // While granted, a rotate searches from the current owner, which becomes ptr.
   assign w_base    = (r_state == GRANT) ? r_idx : r_ptr;
   assign w_found   = (i_req != '0);
   assign w_release = !i_req[r_idx] || (i_ack && (r_cnt == CW'(BURST - 1)));
   assign w_cnt_nxt = r_cnt + 1'b1;

   always_comb begin : sel_blk
      int unsigned v_d;
      int unsigned v_best;
      v_d    = 0;
      v_best = N;
      w_sel  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (i_req[i]) begin
            // distance from base+1, so the base itself ranks last
            v_d = (i + N - 1 - 32'(w_base)) % N;
            if (v_d < v_best) begin
               v_best = v_d;
               w_sel  = IW'(i);
            end
         end
      end
   end

   always_comb begin
      w_sel_oh        = '0;
      w_sel_oh[w_sel] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_ptr   <= IW'(N - 1);
         r_idx   <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state <= GRANT;
                  r_idx   <= w_sel;
                  r_gnt   <= w_sel_oh;
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_last  <= (BURST == 1);
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_ptr <= r_idx;
                  r_cnt <= '0;
                  if (w_found) begin
                     r_idx   <= w_sel;
                     r_gnt   <= w_sel_oh;
                     r_valid <= 1'b1;
                     r_last  <= (BURST == 1);
                  end else begin
                     r_state <= IDLE;
                     r_idx   <= '0;
                     r_gnt   <= '0;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                  end
               end else if (i_ack) begin
                  r_cnt  <= w_cnt_nxt;
                  r_last <= (w_cnt_nxt == CW'(BURST - 1));
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_gnt     = r_gnt;
   assign o_gnt_idx = r_idx;
   assign o_valid   = r_valid;
   assign o_last    = r_last;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench: two arbiters (BURST=1 and BURST=3) share stimulus and are
// compared cycle by cycle against a behavioural round-robin model.
module tb_rr_burst_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] i_req;
   logic       i_ack;

   logic [3:0] a_gnt, b_gnt;
   logic [1:0] a_idx, b_idx;
   logic       a_valid, b_valid, a_last, b_last;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       v;
      logic       l;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int errors = 0;
   int checks = 0;

   // model state per instance: 0 -> BURST=1, 1 -> BURST=3
   bit m_busy[2];
   int m_own[2];
   int m_beat[2];
   int m_ptr[2];
   int m_burst[2] = '{1, 3};

   rr_burst_arbiter #(.N(4), .BURST(1)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_ack(i_ack),
      .o_gnt(a_gnt), .o_gnt_idx(a_idx), .o_valid(a_valid), .o_last(a_last)
   );

   rr_burst_arbiter #(.N(4), .BURST(3)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_ack(i_ack),
      .o_gnt(b_gnt), .o_gnt_idx(b_idx), .o_valid(b_valid), .o_last(b_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int pick(input logic [3:0] req, input int after);
      for (int k = 1; k <= 4; k++) begin
         if (req[(after + k) % 4]) return (after + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset(input int b);
      m_busy[b] = 1'b0;
      m_own[b]  = 0;
      m_beat[b] = 0;
      m_ptr[b]  = 3;
   endtask

   task automatic model_step(input int b, input logic [3:0] req, input logic ack);
      int g;
      if (!m_busy[b]) begin
         g = pick(req, m_ptr[b]);
         if (g >= 0) begin
            m_busy[b] = 1'b1;
            m_own[b]  = g;
            m_beat[b] = 0;
         end
      end else if (!req[m_own[b]] || (ack && m_beat[b] == m_burst[b] - 1)) begin
         m_ptr[b]  = m_own[b];
         m_beat[b] = 0;
         g = pick(req, m_ptr[b]);
         if (g >= 0) m_own[b] = g;
         else        m_busy[b] = 1'b0;
      end else if (ack) begin
         m_beat[b] = m_beat[b] + 1;
      end
   endtask

   function automatic exp_t expect_of(input int b);
      exp_t e;
      e.v   = m_busy[b];
      e.idx = m_busy[b] ? 2'(m_own[b]) : 2'd0;
      e.gnt = m_busy[b] ? 4'(1 << m_own[b]) : 4'd0;
      e.l   = m_busy[b] && (m_beat[b] == m_burst[b] - 1);
      return e;
   endfunction

   task automatic push_both();
      qa.push_back(expect_of(0));
      qb.push_back(expect_of(1));
   endtask

   task automatic cycle(input logic [3:0] req, input logic ack, input bit hold_rst = 1'b0);
      @(negedge clk);
      rst_n = !hold_rst;
      i_req = req;
      i_ack = ack;
      for (int b = 0; b < 2; b++) begin
         if (hold_rst) model_reset(b);
         else          model_step(b, req, ack);
      end
      push_both();
   endtask

   // Asynchronous reset between edges: outputs must clear before the next edge.
   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_gnt, a_idx, a_valid, a_last} !== 8'h00) begin
         errors++;
         $display("FAIL async_reset_a got gnt=%b idx=%0d v=%b l=%b want all zero",
                  a_gnt, a_idx, a_valid, a_last);
      end
      checks++;
      if ({b_gnt, b_idx, b_valid, b_last} !== 8'h00) begin
         errors++;
         $display("FAIL async_reset_b got gnt=%b idx=%0d v=%b l=%b want all zero",
                  b_gnt, b_idx, b_valid, b_last);
      end
      for (int b = 0; b < 2; b++) model_reset(b);
      push_both();
      cycle(4'b0000, 1'b0, 1'b1);
   endtask

   initial begin : monitor
      exp_t e;
      exp_t got;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0) begin
            e   = qa.pop_front();
            got = {a_gnt, a_idx, a_valid, a_last};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL dut_a t=%0t got gnt=%b idx=%0d v=%b l=%b want gnt=%b idx=%0d v=%b l=%b",
                        $time, got.gnt, got.idx, got.v, got.l, e.gnt, e.idx, e.v, e.l);
            end
         end
         if (qb.size() > 0) begin
            e   = qb.pop_front();
            got = {b_gnt, b_idx, b_valid, b_last};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL dut_b t=%0t got gnt=%b idx=%0d v=%b l=%b want gnt=%b idx=%0d v=%b l=%b",
                        $time, got.gnt, got.idx, got.v, got.l, e.gnt, e.idx, e.v, e.l);
            end
         end
      end
   end

   initial begin : driver
      rst_n = 1'b0;
      i_req = '0;
      i_ack = 1'b0;
      for (int b = 0; b < 2; b++) model_reset(b);

      repeat (2) cycle(4'b0000, 1'b0, 1'b1);

      // plain rotation and burst limit
      repeat (8)  cycle(4'b1111, 1'b1);
      repeat (10) cycle(4'b0101, 1'b1);

      // withdraw while unacknowledged
      async_reset();
      repeat (2) cycle(4'b1010, 1'b0);
      repeat (2) cycle(4'b1000, 1'b0);

      // early burst end on a withdrawn request
      async_reset();
      repeat (2) cycle(4'b0011, 1'b1);
      repeat (3) cycle(4'b0010, 1'b1);

      // sole requester, then idle with ack pulses
      repeat (6) cycle(4'b0100, 1'b1);
      cycle(4'b0000, 1'b1);
      repeat (4) cycle(4'b0000, 1'($urandom_range(0, 1)));

      // mid-burst reset, release with all requesting
      repeat (3) cycle(4'b1111, 1'b0);
      async_reset();
      repeat (6) cycle(4'b1111, 1'b1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end

      repeat (3) @(negedge clk);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL drain got qa=%0d qb=%0d want 0 0", qa.size(), qb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Parametrised round-robin arbiter with registered one-hot grants, an ack-per-beat handshake and a per-grant burst limit. It generalises lowest-index priority selection to N requesters with rotating priority. A requester may hold the grant for up to BURST consecutive acknowledged beats before priority rotates. It sits between N requesting masters and one shared downstream resource that acknowledges each completed beat.

## Interface
- N, default 4: number of requesters; must be ≥ 2.
- BURST, default 1: maximum acknowledged beats per grant; must be ≥ 1.

- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_req  input  N  request vector; bit i is requester i.
- i_ack  input  1  downstream accepted the current beat; ignored while o_valid=0.
- o_gnt  output  N  one-hot grant, registered; all zero when idle.
- o_gnt_idx  output  $clog2(N)  index of the granted requester; 0 when idle.
- o_valid  output  1  a grant is active.
- o_last  output  1  the current beat is the final beat of this burst (o_valid && cnt==BURST-1).

## Operation
- Internal state: FSM {IDLE, GRANT}, pointer ptr (last served index), beat counter cnt (counts 0..BURST-1).
- Selection function: the first set bit of i_req, searching ptr+1, ptr+2, … wrapping modulo N, with ptr itself checked last.
- IDLE: if i_req≠0, register the selected requester g → GRANT, with cnt=0 and o_valid=1. Otherwise remain in IDLE.
- GRANT holding g. Cases in priority order:
  - Rotate: i_ack=1 and (cnt==BURST-1 or i_req[g]=0). Set ptr←g and cnt←0, then run the selection on the current i_req. If a requester is found, grant it next cycle with no idle bubble; if only g is still requesting, g is re-granted as a fresh burst. If none is found → IDLE.
  - Continue: i_ack=1, cnt<BURST-1 and i_req[g]=1. Keep g and set cnt←cnt+1.
  - Withdraw: i_ack=0 and i_req[g]=0. Handled exactly as a rotate: ptr←g, cnt←0, re-select.
  - Otherwise hold g and cnt unchanged.
- Request bits of non-granted requesters never affect the current grant.
- o_gnt always equals the one-hot decode of o_gnt_idx when o_valid=1, and is zero otherwise.

## Timing
- Reset (asynchronous, immediate) clears:
  - outputs: o_gnt=0, o_gnt_idx=0, o_valid=0, o_last=0;
  - state: FSM=IDLE, cnt=0, ptr=N-1, so the first grant after reset goes to the lowest-indexed requester.
- Reset asserted mid-burst: the grant is dropped immediately, the burst is lost and no beat is counted.
- Request to grant latency: 1 cycle. i_req is sampled at edge k and o_valid/o_gnt are high after edge k.
- Ack to next grant: 1 cycle, with zero bubble whenever any request is pending at the ack edge.
- All outputs are registered; there is no combinational path from any input to any output.
- With BURST=1, o_last=1 whenever o_valid=1.

## Test plan
- Plain rotation: N=4, BURST=1, i_req=4'b1111, i_ack=1 every cycle → o_gnt_idx sequence 0,1,2,3,0,1 on consecutive cycles; o_valid stays 1.
- Burst limit: N=4, BURST=3, i_req=4'b0101, i_ack=1 every cycle → indices 0,0,0,2,2,2,0; o_last=1 only on every third beat.
- Withdraw: N=4, i_req=4'b1010, index 1 granted. Drop i_req[1] with i_ack=0 → next cycle o_gnt=4'b1000 and o_valid stays 1.
- Early burst end: N=4, BURST=4, i_req=4'b0011, index 0 granted. Ack with i_req[0]=0 on beat 2 → index 1 granted the next cycle, with cnt restarting at 0.
- Sole requester and idle:
  - i_req=4'b0100, BURST=1, ack every cycle → index 2 held continuously with no bubble.
  - Then i_req=0 at an ack → next cycle o_valid=0 and o_gnt=0.
  - i_ack pulses while idle → no state change.
- Asynchronous reset: pull i_rst_n low mid-burst between clock edges → all outputs zero before the next edge. Release with i_req=4'b1111 → index 0 granted first.
